// File: rtl/armleocpu_fetch_queue_pkg.sv
// Shared constants and entry layout for the fetch queue: cache command/response
// codes, instruction exception codes, NOP encoding and the FIFO entry struct.
package armleocpu_fetch_queue_pkg;

   localparam logic [3:0] CACHE_CMD_NONE    = 4'd0;
   localparam logic [3:0] CACHE_CMD_EXECUTE = 4'd1;

   localparam logic [3:0] CACHE_RESPONSE_IDLE        = 4'd0;
   localparam logic [3:0] CACHE_RESPONSE_WAIT        = 4'd1;
   localparam logic [3:0] CACHE_RESPONSE_DONE        = 4'd2;
   localparam logic [3:0] CACHE_RESPONSE_ACCESSFAULT = 4'd3;
   localparam logic [3:0] CACHE_RESPONSE_MISSALIGNED = 4'd4;
   localparam logic [3:0] CACHE_RESPONSE_PAGEFAULT   = 4'd5;

   localparam logic [31:0] EXCEPTION_CODE_INSTRUCTION_ADDRESS_MISSALIGNED = 32'd0;
   localparam logic [31:0] EXCEPTION_CODE_INSTRUCTION_ACCESS_FAULT        = 32'd1;
   localparam logic [31:0] EXCEPTION_CODE_INSTRUCTION_PAGE_FAULT          = 32'd12;

   // addi x0, x0, 0
   localparam logic [31:0] INSTRUCTION_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        err;
      logic [4:0]  cause;
   } fq_entry_t;

   localparam int FQ_ENTRY_W = $bits(fq_entry_t);

   function automatic logic is_fault(input logic [3:0] resp);
      return (resp == CACHE_RESPONSE_ACCESSFAULT) ||
             (resp == CACHE_RESPONSE_MISSALIGNED) ||
             (resp == CACHE_RESPONSE_PAGEFAULT);
   endfunction

   function automatic logic [4:0] fault_cause(input logic [3:0] resp);
      logic [4:0] c;
      c = 5'(EXCEPTION_CODE_INSTRUCTION_ACCESS_FAULT);
      if (resp == CACHE_RESPONSE_MISSALIGNED)
         c = 5'(EXCEPTION_CODE_INSTRUCTION_ADDRESS_MISSALIGNED);
      else if (resp == CACHE_RESPONSE_PAGEFAULT)
         c = 5'(EXCEPTION_CODE_INSTRUCTION_PAGE_FAULT);
      return c;
   endfunction

endpackage

// File: rtl/armleocpu_fetch_queue_if.sv
// Instruction-cache command/response bus between the fetch queue (master)
// and the cache (slave).
interface armleocpu_fetch_queue_if;
   logic        c_reset_done;
   logic [3:0]  c_cmd;
   logic [31:0] c_address;
   logic [3:0]  c_response;
   logic [31:0] c_load_data;

   modport master (
      input  c_reset_done, c_response, c_load_data,
      output c_cmd, c_address
   );

   modport slave (
      output c_reset_done, c_response, c_load_data,
      input  c_cmd, c_address
   );
endinterface

// File: rtl/armleocpu_fetch_queue_fifo.sv
// DEPTH-entry ring buffer of fetch entries; flush empties it and wins over
// push/pop in the same cycle. Head is read straight from storage.
module armleocpu_fetch_queue_fifo
   import armleocpu_fetch_queue_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush_i,
   input  logic          wr_en_i,
   input  fq_entry_t     wr_data_i,
   input  logic          rd_en_i,
   output fq_entry_t     rd_data_o,
   output logic [CW-1:0] count_o
);

   fq_entry_t     mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap on their own
         if (wr_en_i) wr_ptr_d = wr_ptr_q + PW'(1);
         if (rd_en_i) rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(wr_en_i) - CW'(rd_en_i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en_i && !flush_i)
         mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;

endmodule

// File: rtl/armleocpu_fetch_queue.sv
// Decoupled fetch front-end: sequential EXECUTE reads into a DEPTH-entry FIFO,
// redirect flush/drop. Define ARMLEOCPU_FETCH_QUEUE_BYPASS_EN for 0-cycle empty-FIFO bypass.
module armleocpu_fetch_queue
   import armleocpu_fetch_queue_pkg::*;
#(
   parameter  int          DEPTH        = 4,
   parameter  logic [31:0] RESET_VECTOR = 32'h0000_2000,
   localparam int          CW           = $clog2(DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   armleocpu_fetch_queue_if.master  cache,
   input  logic                     redirect_valid,
   input  logic [31:0]              redirect_pc,
   output logic                     f2e_valid,
   input  logic                     f2e_ready,
   output logic [31:0]              f2e_instr,
   output logic [31:0]              f2e_pc,
   output logic                     f2e_err,
   output logic [31:0]              f2e_cause,
   output logic [CW-1:0]            fq_count
);

   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        outstanding_q, outstanding_d;
   logic        drop_q, drop_d;
   logic        stalled_q, stalled_d;

   logic        resp_done, resp_fault, resp_fin, resp_take;
   logic        issue, byp, fifo_wr, fifo_rd;
   logic [CW-1:0] fifo_count, reserved;
   fq_entry_t   resp_entry, head, out_entry;

   assign resp_done  = (cache.c_response == CACHE_RESPONSE_DONE);
   assign resp_fault = is_fault(cache.c_response);
   assign resp_fin   = outstanding_q && (resp_done || resp_fault);
   // A response finishing under a pending drop or a redirect never reaches the queue
   assign resp_take  = resp_fin && !drop_q && !redirect_valid;

   always_comb begin
      resp_entry.pc    = req_pc_q;
      resp_entry.instr = resp_fault ? INSTRUCTION_NOP : cache.c_load_data;
      resp_entry.err   = resp_fault;
      resp_entry.cause = resp_fault ? fault_cause(cache.c_response) : 5'd0;
   end

`ifdef ARMLEOCPU_FETCH_QUEUE_BYPASS_EN
   assign byp = resp_take && (fifo_count == '0);
`else
   assign byp = 1'b0;
`endif

   assign fifo_wr = resp_take && !(byp && f2e_ready);
   assign fifo_rd = f2e_ready && (fifo_count != '0);

   armleocpu_fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush_i   (redirect_valid),
      .wr_en_i   (fifo_wr),
      .wr_data_i (resp_entry),
      .rd_en_i   (fifo_rd),
      .rd_data_o (head),
      .count_o   (fifo_count)
   );

   // Entries already stored plus the one landing now; the new request needs a free slot beyond that
   assign reserved = fifo_count + CW'(fifo_wr);

   assign issue = rst_n && cache.c_reset_done && !stalled_q && !redirect_valid &&
                  (!outstanding_q || resp_fin) &&
                  !(resp_fin && resp_fault && !drop_q) &&
                  (reserved < CW'(DEPTH));

   assign cache.c_cmd     = issue ? CACHE_CMD_EXECUTE : CACHE_CMD_NONE;
   assign cache.c_address = fetch_pc_q;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      req_pc_d      = req_pc_q;
      outstanding_d = outstanding_q;
      drop_d        = drop_q;
      stalled_d     = stalled_q;
      if (resp_fin) begin
         outstanding_d = 1'b0;
         drop_d        = 1'b0;
         if (resp_take && resp_fault) stalled_d = 1'b1;
      end
      if (issue) begin
         outstanding_d = 1'b1;
         req_pc_d      = fetch_pc_q;
         fetch_pc_d    = fetch_pc_q + 32'd4;
      end
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
         stalled_d  = 1'b0;
         drop_d     = outstanding_q && !resp_fin;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q    <= RESET_VECTOR;
         req_pc_q      <= RESET_VECTOR;
         outstanding_q <= 1'b0;
         drop_q        <= 1'b0;
         stalled_q     <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         req_pc_q      <= req_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         stalled_q     <= stalled_d;
      end
   end

   assign out_entry = byp ? resp_entry : head;
   assign f2e_valid = byp || (fifo_count != '0);
   assign f2e_pc    = out_entry.pc;
   assign f2e_instr = out_entry.instr;
   // Storage is not reset, so fault flags are qualified by valid
   assign f2e_err   = f2e_valid && out_entry.err;
   assign f2e_cause = f2e_err ? {27'd0, out_entry.cause} : 32'd0;
   assign fq_count  = fifo_count;

endmodule

// File: tb/tb_armleocpu_fetch_queue.sv
// Directed bench for armleocpu_fetch_queue with a small behavioural I-cache.
module tb_armleocpu_fetch_queue;
   import armleocpu_fetch_queue_pkg::*;

   logic        clk, rst_n;
   logic        redirect_valid, f2e_ready, f2e_valid, f2e_err;
   logic [31:0] redirect_pc, f2e_instr, f2e_pc, f2e_cause;
   logic [2:0]  fq_count;

   armleocpu_fetch_queue_if cif();

   armleocpu_fetch_queue #(.DEPTH(4), .RESET_VECTOR(32'h0000_2000)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cache          (cif),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .f2e_valid      (f2e_valid),
      .f2e_ready      (f2e_ready),
      .f2e_instr      (f2e_instr),
      .f2e_pc         (f2e_pc),
      .f2e_err        (f2e_err),
      .f2e_cause      (f2e_cause),
      .fq_count       (fq_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   // cache model + monitor
   logic [31:0] issue_q[$], pop_pc[$], pop_instr[$], pop_cause[$];
   logic        pop_err[$];
   int          lat, cnt, max_cnt;
   bit          busy, hold_en, cmd_seen, fin_seen;
   logic [31:0] m_addr, addr_seen, hold_addr, fault_addr;
   logic [3:0]  fault_code;

   initial begin
      busy = 0; cnt = 0; m_addr = '0;
      cif.c_response  = CACHE_RESPONSE_IDLE;
      cif.c_load_data = '0;
      forever begin
         @(negedge clk);
         cmd_seen  = (cif.c_cmd == CACHE_CMD_EXECUTE);
         addr_seen = cif.c_address;
         fin_seen  = (cif.c_response == CACHE_RESPONSE_DONE) ||
                     (cif.c_response == CACHE_RESPONSE_ACCESSFAULT) ||
                     (cif.c_response == CACHE_RESPONSE_MISSALIGNED) ||
                     (cif.c_response == CACHE_RESPONSE_PAGEFAULT);
         if (cmd_seen) issue_q.push_back(addr_seen);
         if (f2e_valid && f2e_ready) begin
            pop_pc.push_back(f2e_pc);
            pop_instr.push_back(f2e_instr);
            pop_err.push_back(f2e_err);
            pop_cause.push_back(f2e_cause);
         end
         if (32'(fq_count) > 32'(max_cnt)) max_cnt = int'(fq_count);
         @(posedge clk);
         #1;
         if (!rst_n) busy = 0;
         else begin
            if (fin_seen) busy = 0;
            if (cmd_seen) begin busy = 1; m_addr = addr_seen; cnt = lat; end
         end
         cif.c_load_data = 32'hBAD0_BAD0;
         if (!busy) cif.c_response = CACHE_RESPONSE_IDLE;
         else if (hold_en && m_addr == hold_addr) cif.c_response = CACHE_RESPONSE_WAIT;
         else if (cnt > 0) begin cif.c_response = CACHE_RESPONSE_WAIT; cnt--; end
         else if (m_addr[1:0] != 2'b00) cif.c_response = CACHE_RESPONSE_MISSALIGNED;
         else if (m_addr == fault_addr) cif.c_response = fault_code;
         else begin
            cif.c_response  = CACHE_RESPONSE_DONE;
            cif.c_load_data = mdata(m_addr);
         end
      end
   end

   task automatic clear_q();
      issue_q.delete(); pop_pc.delete(); pop_instr.delete();
      pop_err.delete(); pop_cause.delete();
   endtask

   task automatic redirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      step();
      redirect_valid = 1'b0;
   endtask

   task automatic wait_pops(input int n, input string tag);
      for (int i = 0; i < 60 && pop_pc.size() < n; i++) step();
      chk(tag, 32'(pop_pc.size() >= n), 32'd1);
   endtask

   task automatic wait_issues(input int n, input string tag);
      for (int i = 0; i < 60 && issue_q.size() < n; i++) step();
      chk(tag, 32'(issue_q.size() >= n), 32'd1);
   endtask

   int n200c;

   initial begin
      rst_n = 1'b0; cif.c_reset_done = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      f2e_ready = 1'b0; lat = 1; hold_en = 0; hold_addr = '0; max_cnt = 0;
      fault_addr = 32'h1; fault_code = CACHE_RESPONSE_ACCESSFAULT;
      repeat (3) step();
      chk("rst_valid", 32'(f2e_valid), 32'd0);
      chk("rst_count", 32'(fq_count), 32'd0);
      chk("rst_cmd",   32'(cif.c_cmd), 32'(CACHE_CMD_NONE));
      chk("rst_err",   32'(f2e_err), 32'd0);

      // cache not ready: nothing issued
      rst_n = 1'b1;
      clear_q();
      repeat (4) step();
      chk("noready_issue", 32'(issue_q.size()), 32'd0);

      // 1: streaming with one WAIT per access
      f2e_ready = 1'b1; cif.c_reset_done = 1'b1; max_cnt = 0;
      wait_pops(3, "t1_pops");
      chk("t1_pc0", pop_pc[0], 32'h2000);
      chk("t1_pc1", pop_pc[1], 32'h2004);
      chk("t1_pc2", pop_pc[2], 32'h2008);
      chk("t1_in1", pop_instr[1], mdata(32'h2004));
      chk("t1_ad0", issue_q[0], 32'h2000);
      chk("t1_ad2", issue_q[2], 32'h2008);
      chk("t1_max", 32'(max_cnt <= 1), 32'd1);

      // 2: execute stalls, queue fills to DEPTH
      f2e_ready = 1'b0;
      redirect(32'h4000);
      clear_q();
      repeat (20) step();
      chk("t2_issues", 32'(issue_q.size()), 32'd4);
      chk("t2_count",  32'(fq_count), 32'd4);
      chk("t2_cmd",    32'(cif.c_cmd), 32'(CACHE_CMD_NONE));
      chk("t2_ad3",    issue_q[3], 32'h400C);
      f2e_ready = 1'b1;
      wait_pops(4, "t2_pops");
      chk("t2_pc0", pop_pc[0], 32'h4000);
      chk("t2_pc1", pop_pc[1], 32'h4004);
      chk("t2_pc2", pop_pc[2], 32'h4008);
      chk("t2_pc3", pop_pc[3], 32'h400C);
      wait_issues(5, "t2_resume");
      chk("t2_ad4", issue_q[4], 32'h4010);

      // 3: redirect while a fetch is waiting
      hold_addr = 32'h200C; hold_en = 1;
      redirect(32'h200C);
      clear_q();
      for (int i = 0; i < 40 && !(issue_q.size() > 0 && issue_q[$] == 32'h200C); i++) step();
      chk("t3_issued", issue_q[$], 32'h200C);
      repeat (2) step();
      redirect(32'h8000);
      chk("t3_flush", 32'(fq_count), 32'd0);
      hold_en = 0;
      wait_pops(1, "t3_pops");
      chk("t3_pc",  pop_pc[0], 32'h8000);
      chk("t3_in",  pop_instr[0], mdata(32'h8000));
      n200c = 0;
      foreach (pop_pc[i]) if (pop_pc[i] == 32'h200C) n200c++;
      chk("t3_drop", 32'(n200c), 32'd0);

      // 4: page fault stalls fetch until redirect
      f2e_ready = 1'b0; fault_addr = 32'h3000; fault_code = CACHE_RESPONSE_PAGEFAULT;
      redirect(32'h3000);
      clear_q();
      for (int i = 0; i < 30 && !f2e_valid; i++) step();
      chk("t4_valid", 32'(f2e_valid), 32'd1);
      chk("t4_err",   32'(f2e_err), 32'd1);
      chk("t4_cause", f2e_cause, 32'd12);
      chk("t4_pc",    f2e_pc, 32'h3000);
      chk("t4_nop",   f2e_instr, INSTRUCTION_NOP);
      repeat (10) step();
      chk("t4_stall", 32'(issue_q.size()), 32'd1);
      chk("t4_cmd",   32'(cif.c_cmd), 32'(CACHE_CMD_NONE));
      f2e_ready = 1'b1; fault_addr = 32'h1;
      redirect(32'h100);
      clear_q();
      wait_pops(1, "t4_pops");
      chk("t4_rpc",  pop_pc[0], 32'h100);
      chk("t4_rerr", 32'(pop_err[0]), 32'd0);

      // 5: PC wrap and misaligned redirect
      redirect(32'hFFFF_FFFC);
      clear_q();
      wait_issues(2, "t5_issues");
      chk("t5_ad0", issue_q[0], 32'hFFFF_FFFC);
      chk("t5_wrap", issue_q[1], 32'h0000_0000);
      redirect(32'h2002);
      clear_q();
      wait_pops(1, "t5_pops");
      chk("t5_pc",    pop_pc[0], 32'h2002);
      chk("t5_err",   32'(pop_err[0]), 32'd1);
      chk("t5_cause", pop_cause[0], 32'd0);
      chk("t5_nop",   pop_instr[0], INSTRUCTION_NOP);

      // 6: async reset with a nearly full queue and a waiting fetch
      f2e_ready = 1'b0; lat = 3;
      redirect(32'h5000);
      for (int i = 0; i < 60 && !(fq_count == 3'd3 && cif.c_response == CACHE_RESPONSE_WAIT); i++) step();
      chk("t6_fill", 32'(fq_count), 32'd3);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_valid", 32'(f2e_valid), 32'd0);
      chk("t6_count", 32'(fq_count), 32'd0);
      chk("t6_cmd",   32'(cif.c_cmd), 32'(CACHE_CMD_NONE));
      repeat (2) step();
      rst_n = 1'b1;
      clear_q();
      wait_issues(1, "t6_issue");
      chk("t6_ad0", issue_q[0], 32'h2000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
